// File: rtl/bram_req_ctrl.sv
// -----------------------------------------------------------------------------
// bram_req_ctrl
//
// Request-side controller for a single-port block RAM. Upstream read/write
// commands arrive on a valid/ready port and are issued to the RAM one per
// cycle. The RAM's 1-cycle read latency is absorbed by tracking the
// outstanding read and capturing bram_datao into a 2-entry response FIFO,
// which drains in command order on a valid/ready port. After reset the whole
// RAM is optionally zero-filled before commands are accepted.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  command accepted when cmd_valid && cmd_ready
//   cmd_wr      in   1 = write, 0 = read
//   cmd_addr    in   command address
//   cmd_wdata   in   write data
//   rsp_valid   out  read data available
//   rsp_ready   in   consumer accepts rsp_rdata
//   rsp_rdata   out  read data, command order
//   init_done   out  high once the controller is in RUN
//   bram_en     out  RAM enable
//   bram_wen    out  RAM write enable
//   bram_addr   out  RAM address
//   bram_datai  out  RAM write data
//   bram_datao  in   RAM read data, valid 1 cycle after a read enable
// -----------------------------------------------------------------------------
module bram_req_ctrl #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          CLEAR_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  bram_en,
   output logic                  bram_wen,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_datai,
   input  logic [DATA_WIDTH-1:0] bram_datao
);

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;
   localparam logic ST_INIT  = CLEAR_EN ? ST_CLEAR : ST_RUN;

   logic                  state_q,   state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [1:0]            cnt_q,     cnt_d;
   logic                  wr_ptr_q,  wr_ptr_d;
   logic                  rd_ptr_q,  rd_ptr_d;
   logic [DATA_WIDTH-1:0] ent0_q,    ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q,    ent1_d;

   logic       run;
   logic       pop;
   logic       push;
   logic [2:0] occ;
   logic       ready_int;
   logic       accept;

   always_comb begin
      run  = (state_q == ST_RUN);
      pop  = (cnt_q != 2'd0) && rsp_ready;
      push = rd_pend_q;
      // Occupancy counts the in-flight read as already owning a slot; a pop
      // this cycle frees one, hence the combinational rsp_ready -> cmd_ready.
      occ       = {1'b0, cnt_q} + {2'b00, rd_pend_q};
      ready_int = run && ((occ - {2'b00, pop}) < 3'd2);
      accept    = cmd_valid && ready_int;

      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == '1) begin
            state_d = ST_RUN;
         end
      end

      rd_pend_d = accept && !cmd_wr;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ent0_d   = ent0_q;
      ent1_d   = ent1_q;
      if (push) begin
         if (wr_ptr_q) begin
            ent1_d = bram_datao;
         end else begin
            ent0_d = bram_datao;
         end
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
         rd_pend_q <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         ent0_q    <= '0;
         ent1_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rd_pend_q <= rd_pend_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ent0_q    <= ent0_d;
         ent1_q    <= ent1_d;
      end
   end

   // Outputs are gated by reset directly so they read as idle for the whole
   // time reset is held, including the RUN-at-reset case when CLEAR_EN=0.
   always_comb begin
      cmd_ready  = reset && ready_int;
      init_done  = reset && run;
      rsp_valid  = (cnt_q != 2'd0);
      rsp_rdata  = rd_ptr_q ? ent1_q : ent0_q;
      bram_en    = 1'b0;
      bram_wen   = 1'b0;
      bram_addr  = '0;
      bram_datai = '0;
      if (reset) begin
         if (run) begin
            bram_en    = accept;
            bram_wen   = accept && cmd_wr;
            bram_addr  = cmd_addr;
            bram_datai = cmd_wdata;
         end else begin
            bram_en    = 1'b1;
            bram_wen   = 1'b1;
            bram_addr  = clr_cnt_q;
         end
      end
   end

endmodule
